// File: rtl/bw_pkg.sv
// bw_pkg: shared geometry, accumulator width, FSM states and RAM address type for the BW capture path
package bw_pkg;
   localparam int IMG_DIM = 28;
   localparam int IMG_PIXELS = 784;
   localparam int SCALE = 8;
   localparam int ROI_DIM = 224;
   localparam int ACC_W = 14;
   typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DONE} bw_cap_state_t;
   typedef logic [9:0] bw_addr_t;
endpackage

// File: rtl/bw_capture_if.sv
// bw_capture_if: raster luminance stream from the camera/VGA source, with frame origin marker
interface bw_capture_if;
   import bw_pkg::*;
   logic frame_start;
   logic pix_valid;
   bw_addr_t pix_x;
   bw_addr_t pix_y;
   logic [7:0] pix_lum;
   modport master (output frame_start, pix_valid, pix_x, pix_y, pix_lum);
   modport slave (input frame_start, pix_valid, pix_x, pix_y, pix_lum);
endinterface

// File: rtl/bw_row_accum.sv
// bw_row_accum: one partial block sum per cell column of the cell row currently streaming past
module bw_row_accum import bw_pkg::*; (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic load,
   input  logic [4:0] col,
   input  logic [7:0] lum,
   output logic [ACC_W-1:0] sum
);
   logic [ACC_W-1:0] acc [IMG_DIM];
   assign sum = acc[col] + ACC_W'(lum);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) for (int i = 0; i < IMG_DIM; i++) acc[i] <= '0;
      else if (en) acc[col] <= load ? ACC_W'(lum) : sum;
endmodule

// File: rtl/bw_capture.sv
// bw_capture: crops a 224x224 ROI, box-averages each 8x8 block to one bit, writes the 28x28 image
module bw_capture import bw_pkg::*; #(
   parameter int X0 = 208,
   parameter int Y0 = 128,
   parameter int THRESH = 128,
   parameter bit INVERT = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   bw_capture_if.slave pix,
   output logic bw_wren,
   output bw_addr_t bw_wraddr,
   output logic bw_wrdata,
   output logic pixl_ready,
   output logic busy
);
   bw_cap_state_t state, state_nxt;
   bw_addr_t lx, ly, cnt;
   logic [ACC_W-1:0] sum;
   logic acc_en, wr_fire, restart;
   assign lx = pix.pix_x - bw_addr_t'(X0);
   assign ly = pix.pix_y - bw_addr_t'(Y0);
   assign acc_en = pix.pix_valid && pix.pix_x >= bw_addr_t'(X0) && lx < bw_addr_t'(ROI_DIM)
                && pix.pix_y >= bw_addr_t'(Y0) && ly < bw_addr_t'(ROI_DIM);
   assign restart = pix.frame_start && (state == WAIT_FRAME || state == CAPTURE);
   // frame_start beats a completing pixel arriving in the same cycle
   assign wr_fire = acc_en && &lx[2:0] && &ly[2:0] && state == CAPTURE && !pix.frame_start;
   assign busy = state == WAIT_FRAME || state == CAPTURE;
   assign pixl_ready = state == DONE;

   bw_row_accum u_accum (
      .clk,
      .reset_n,
      .en(acc_en),
      .load(lx[2:0] == 3'd0 && ly[2:0] == 3'd0),
      .col(lx[7:3]),
      .lum(pix.pix_lum),
      .sum
   );

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:       state_nxt = start ? WAIT_FRAME : IDLE;
         WAIT_FRAME: state_nxt = pix.frame_start ? CAPTURE : WAIT_FRAME;
         CAPTURE:    state_nxt = (bw_wren && bw_wraddr == bw_addr_t'(IMG_PIXELS - 1)) ? DONE : CAPTURE;
         DONE:       state_nxt = IDLE;
      endcase
   end

   // raster order makes the running cell count equal to r*28+c
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         bw_wren <= 1'b0;
         bw_wraddr <= '0;
         bw_wrdata <= 1'b0;
         cnt <= '0;
      end else begin
         bw_wren <= wr_fire;
         cnt <= restart ? '0 : wr_fire ? cnt + 1'b1 : cnt;
         if (wr_fire) begin
            bw_wraddr <= cnt;
            bw_wrdata <= (sum >= ACC_W'(THRESH * SCALE * SCALE)) ^ INVERT;
         end
      end
endmodule

// File: tb/tb_bw_capture.sv
// tb_bw_capture: random images against a block-average reference model, plus threshold, abort and reset cases
module tb_bw_capture;
   import bw_pkg::*;
   localparam int X0 = 208;
   localparam int Y0 = 128;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic wren, wrdata, rdy, busy, wren_i, wrdata_i, rdy_i, busy_i;
   bw_addr_t wraddr, wraddr_i;
   bw_capture_if pif();

   bw_capture dut (
      .clk, .reset_n, .start, .pix(pif),
      .bw_wren(wren), .bw_wraddr(wraddr), .bw_wrdata(wrdata), .pixl_ready(rdy), .busy(busy)
   );
   bw_capture #(.INVERT(1'b1)) dut_inv (
      .clk, .reset_n, .start, .pix(pif),
      .bw_wren(wren_i), .bw_wraddr(wraddr_i), .bw_wrdata(wrdata_i), .pixl_ready(rdy_i), .busy(busy_i)
   );

   always #5 clk = ~clk;

   int n_chk, n_err, rd, rdy_n, rdy_i_n, rdy_bad, max_addr;
   bit prev783;
   bw_addr_t wq_addr[$], wqi_addr[$];
   logic wq_dat[$], wqi_dat[$];
   logic [7:0] img [ROI_DIM][ROI_DIM];
   bit ref_bits [IMG_PIXELS];

   always @(negedge clk) begin
      if (wren) begin wq_addr.push_back(wraddr); wq_dat.push_back(wrdata); end
      if (wren_i) begin wqi_addr.push_back(wraddr_i); wqi_dat.push_back(wrdata_i); end
      if (rdy) begin rdy_n++; if (!prev783) rdy_bad++; end
      if (rdy_i) rdy_i_n++;
      if (wren && int'(wraddr) > max_addr) max_addr = int'(wraddr);
      prev783 = wren && wraddr == 10'd783;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input bit st, input bit fs, input bit v, input int x, input int y, input int lum);
      @(negedge clk);
      start = st;
      pif.frame_start = fs;
      pif.pix_valid = v;
      pif.pix_x = 10'(x);
      pif.pix_y = 10'(y);
      pif.pix_lum = 8'(lum);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 0, 0, 0);
   endtask

   task automatic fill_block(input int r, input int c, input int lo, input int hi);
      for (int dy = 0; dy < SCALE; dy++)
         for (int dx = 0; dx < SCALE; dx++)
            img[r*SCALE+dy][c*SCALE+dx] = 8'($urandom_range(hi, lo));
   endtask

   function automatic int block_sum(input int r, input int c);
      int s = 0;
      for (int dy = 0; dy < SCALE; dy++)
         for (int dx = 0; dx < SCALE; dx++)
            s += int'(img[r*SCALE+dy][c*SCALE+dx]);
      return s;
   endfunction

   // cells are dark, bright, or straddle the 128 average so sums land near the threshold
   task automatic gen_img();
      for (int r = 0; r < IMG_DIM; r++)
         for (int c = 0; c < IMG_DIM; c++)
            case ($urandom_range(0, 2))
               0: fill_block(r, c, 0, 127);
               1: fill_block(r, c, 128, 255);
               default: fill_block(r, c, 124, 132);
            endcase
      for (int k = 0; k < IMG_PIXELS; k++) ref_bits[k] = block_sum(k / IMG_DIM, k % IMG_DIM) >= 128 * 64;
   endtask

   task automatic drive_block(input int r, input int c);
      for (int dy = 0; dy < SCALE; dy++)
         for (int dx = 0; dx < SCALE; dx++)
            cyc(0, 0, 1, X0 + c*SCALE + dx, Y0 + r*SCALE + dy, img[r*SCALE+dy][c*SCALE+dx]);
   endtask

   task automatic drive_rows(input int nrows);
      cyc(0, 0, 1, X0 + 5, Y0 - 1, 255);
      for (int y = 0; y < nrows; y++) begin
         if (y == 100) cyc(1, 0, 0, 0, 0, 0);
         cyc(0, 0, 1, X0 - 1, Y0 + y, 255);
         for (int x = 0; x < ROI_DIM; x++) begin
            if ($urandom_range(0, 31) == 0) cyc(0, 0, 0, X0 + x, Y0 + y, $urandom_range(0, 255));
            cyc(0, 0, 1, X0 + x, Y0 + y, img[y][x]);
         end
         cyc(0, 0, 1, X0 + ROI_DIM, Y0 + y, 255);
      end
      cyc(0, 0, 1, X0 + 7, Y0 + ROI_DIM + 7, 255);
   endtask

   task automatic check_writes(input int n, input string tag);
      int got = wq_addr.size() - rd;
      check({tag, "_count"}, got, n);
      check({tag, "_inv_count"}, wqi_addr.size() - rd, n);
      for (int k = 0; k < n && k < got; k++) begin
         check({tag, "_addr"}, wq_addr[rd+k], k);
         check({tag, "_data"}, wq_dat[rd+k], ref_bits[k]);
         check({tag, "_inv_addr"}, wqi_addr[rd+k], k);
         check({tag, "_inv_data"}, wqi_dat[rd+k], !ref_bits[k]);
      end
      rd = wq_addr.size();
   endtask

   initial begin
      pif.frame_start = 1'b0;
      pif.pix_valid = 1'b0;
      pif.pix_x = '0;
      pif.pix_y = '0;
      pif.pix_lum = '0;
      repeat (3) @(negedge clk);
      check("rst_wren", wren, 0);
      check("rst_wraddr", wraddr, 0);
      check("rst_wrdata", wrdata, 0);
      check("rst_ready", rdy, 0);
      check("rst_busy", busy, 0);
      reset_n = 1'b1;
      idle(2);
      check("idle_busy", busy, 0);
      cyc(1, 0, 0, 0, 0, 0);
      check("busy_pre", busy, 0);
      cyc(0, 0, 0, 0, 0, 0);
      check("busy_rise", busy, 1);
      check("busy_rise_inv", busy_i, 1);
      cyc(0, 1, 0, 0, 0, 0);
      // cell (0,0) summing to 8191, then to 8192 after an abort
      for (int dy = 0; dy < SCALE; dy++)
         for (int dx = 0; dx < SCALE; dx++) img[dy][dx] = 8'd128;
      img[$urandom_range(0, 7)][$urandom_range(0, 7)] = 8'd127;
      drive_block(0, 0);
      idle(4);
      ref_bits[0] = 1'b0;
      check_writes(1, "edge_lo");
      cyc(0, 1, 0, 0, 0, 0);
      for (int dy = 0; dy < SCALE; dy++)
         for (int dx = 0; dx < SCALE; dx++) img[dy][dx] = 8'd128;
      drive_block(0, 0);
      idle(4);
      ref_bits[0] = 1'b1;
      check_writes(1, "edge_hi");
      fill_block(0, 1, 0, 255);
      drive_block(0, 1);
      @(posedge clk);
      #1;
      check("pre_rst_wren", wren, 1);
      check("pre_rst_addr", wraddr, 1);
      check("pre_rst_data", wrdata, block_sum(0, 1) >= 128 * 64);
      reset_n = 1'b0;
      #1;
      check("mid_rst_wren", wren, 0);
      check("mid_rst_wraddr", wraddr, 0);
      check("mid_rst_wrdata", wrdata, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_busy_inv", busy_i, 0);
      check("mid_rst_ready", rdy, 0);
      @(negedge clk);
      reset_n = 1'b1;
      idle(2);
      rd = wq_addr.size();
      check("post_rst_busy", busy, 0);
      check("no_ready_yet", rdy_n, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      check("busy_restart", busy, 1);
      cyc(0, 1, 0, 0, 0, 0);
      gen_img();
      drive_rows(16);
      idle(4);
      check_writes(2 * IMG_DIM, "abort_pass");
      cyc(0, 1, 0, 0, 0, 0);
      check("abort_no_ready", rdy_n, 0);
      gen_img();
      drive_rows(ROI_DIM);
      idle(4);
      check_writes(IMG_PIXELS, "full");
      check("ready_pulses", rdy_n, 1);
      check("ready_pulses_inv", rdy_i_n, 1);
      check("ready_after_783", rdy_bad, 0);
      check("max_wraddr", max_addr, IMG_PIXELS - 1);
      check("done_busy", busy, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
